// File: rtl/axi4_video_chk_pkg.sv
// Shared definitions for the AXI4-Stream video frame checker.
// Holds the FSM state type, the error flag bit positions and the CRC-32 constants.
package axi4_video_chk_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF  = 2'd0,
      ACTIVE    = 2'd1,
      DRAIN_EOL = 2'd2
   } state_t;

   localparam int ERR_SHORT_LINE  = 0;
   localparam int ERR_LONG_LINE   = 1;
   localparam int ERR_EARLY_SOF   = 2;
   localparam int ERR_SHORT_FRAME = 3;

   localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

   localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/video_crc32.sv
// Word-parallel CRC-32 (MSB first, no reflection) over a TDATA_WIDTH-bit beat.
// init_i restarts the running value; with en_i the beat is folded in on top of
// the restarted value in the same cycle. crc_upd_o is the running value with the
// current beat folded in, for callers that need the result before the register.
module video_crc32
   import axi4_video_chk_pkg::*;
#(
   parameter int TDATA_WIDTH = 32
) (
   input  logic                   clk_i,
   input  logic                   init_i,
   input  logic                   en_i,
   input  logic [TDATA_WIDTH-1:0] data_i,
   output logic [31:0]            crc_o,
   output logic [31:0]            crc_upd_o
);

   function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                            input logic [TDATA_WIDTH-1:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = TDATA_WIDTH - 1; i >= 0; i--) begin
         if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else              c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   logic [31:0] crc_q;

   assign crc_o     = crc_q;
   assign crc_upd_o = crc_step(crc_q, data_i);

   // Running CRC register; seeded at each frame start, so it carries no reset
   always_ff @(posedge clk_i) begin
      if (en_i)        crc_q <= crc_step(init_i ? CRC_INIT : crc_q, data_i);
      else if (init_i) crc_q <= CRC_INIT;
   end

endmodule

// File: rtl/axi4_video_frame_checker.sv
// AXI4-Stream video sink that checks frame geometry (X_ACTIVE x Y_ACTIVE).
// Reports per-frame pass/fail, sticky error flags and frame/error counters.
// Optional macro FRAME_CRC_EN adds a CRC-32 over the counted pixels of each frame;
// without it frame_crc_o is constant 0.
module axi4_video_frame_checker
   import axi4_video_chk_pkg::*;
#(
   parameter int TDATA_WIDTH = 32,
   parameter int X_ACTIVE    = 1920,
   parameter int Y_ACTIVE    = 1080
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [TDATA_WIDTH-1:0] video_i_tdata,
   input  logic                   video_i_tvalid,
   input  logic                   video_i_tlast,
   input  logic                   video_i_tuser,
   output logic                   video_i_tready,
   input  logic                   err_clr_i,
   output logic                   frame_done_o,
   output logic                   frame_ok_o,
   output logic [3:0]             err_flags_o,
   output logic [31:0]            frame_cnt_o,
   output logic [15:0]            err_frame_cnt_o,
   output logic [31:0]            frame_crc_o
);

   localparam int XW = $clog2(X_ACTIVE + 1);
   localparam int YW = $clog2(Y_ACTIVE + 1);
   localparam logic [XW-1:0] X_LAST = XW'(X_ACTIVE - 1);
   localparam logic [YW-1:0] Y_END  = YW'(Y_ACTIVE);

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d, bx;
   logic [YW-1:0] y_q, y_d, by, y_inc, by_inc;
   logic          ferr_q, ferr_d, be;
   logic          beat, start, abort, count, short_line;
   logic [3:0]    err_set;
   logic          done_d, ok_d;
   logic          crc_init, crc_en, end_counted;
   logic          vld_p1;

   assign beat         = video_i_tvalid & video_i_tready;
   assign frame_done_o = vld_p1;

   // Next-state and per-beat geometry checks
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      ferr_d      = ferr_q;
      err_set     = '0;
      done_d      = 1'b0;
      ok_d        = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      count       = 1'b0;
      crc_init    = 1'b0;
      crc_en      = 1'b0;
      end_counted = 1'b0;
      short_line  = 1'b0;
      y_inc       = y_q + 1'b1;

      if (beat) begin
         unique case (state_q)
            WAIT_SOF: begin
               start = video_i_tuser;
            end
            ACTIVE: begin
               abort = video_i_tuser;
               start = video_i_tuser;
               count = ~video_i_tuser;
            end
            DRAIN_EOL: begin
               abort = video_i_tuser;
               start = video_i_tuser;
               if (!video_i_tuser && video_i_tlast) begin
                  x_d = '0;
                  if (y_inc == Y_END) begin
                     done_d  = 1'b1;
                     ok_d    = ~ferr_q;
                     y_d     = '0;
                     state_d = WAIT_SOF;
                  end else begin
                     y_d     = y_inc;
                     state_d = ACTIVE;
                  end
               end
            end
            default: state_d = WAIT_SOF;
         endcase
      end

      // An SOF inside a frame closes the old frame as failed
      if (abort) begin
         err_set[ERR_EARLY_SOF]   = 1'b1;
         err_set[ERR_SHORT_FRAME] = 1'b1;
         done_d = 1'b1;
         ok_d   = 1'b0;
      end

      // A starting beat is pixel 0 of line 0 of a clean frame
      bx     = start ? '0   : x_q;
      by     = start ? '0   : y_q;
      be     = start ? 1'b0 : ferr_q;
      by_inc = by + 1'b1;

      if (start || count) begin
         crc_en   = 1'b1;
         crc_init = start;
         if (video_i_tlast) begin
            short_line = (bx != X_LAST);
            err_set[ERR_SHORT_LINE] = short_line;
            x_d    = '0;
            ferr_d = be | short_line;
            if (by_inc == Y_END) begin
               done_d      = 1'b1;
               ok_d        = ~(be | short_line);
               end_counted = 1'b1;
               y_d         = '0;
               state_d     = WAIT_SOF;
            end else begin
               y_d     = by_inc;
               state_d = ACTIVE;
            end
         end else if (bx == X_LAST) begin
            err_set[ERR_LONG_LINE] = 1'b1;
            x_d     = bx;
            y_d     = by;
            ferr_d  = 1'b1;
            state_d = DRAIN_EOL;
         end else begin
            x_d     = bx + 1'b1;
            y_d     = by;
            ferr_d  = be;
            state_d = ACTIVE;
         end
      end
   end

   // FSM state and position counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= WAIT_SOF;
         x_q     <= '0;
         y_q     <= '0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ferr_q  <= ferr_d;
      end
   end

   // ---- stage p1: frame result, sticky flags and counters ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         video_i_tready  <= 1'b0;
         vld_p1          <= 1'b0;
         frame_ok_o      <= 1'b0;
         err_flags_o     <= '0;
         frame_cnt_o     <= '0;
         err_frame_cnt_o <= '0;
      end else begin
         video_i_tready <= 1'b1;
         vld_p1         <= done_d;
         err_flags_o    <= (err_clr_i ? 4'b0000 : err_flags_o) | err_set;
         if (done_d) begin
            frame_ok_o <= ok_d;
            if (ok_d)                                frame_cnt_o     <= frame_cnt_o + 32'd1;
            else if (err_frame_cnt_o != ERR_CNT_MAX) err_frame_cnt_o <= err_frame_cnt_o + 16'd1;
         end
      end
   end

`ifdef FRAME_CRC_EN
   logic [31:0] crc_q, crc_upd;

   video_crc32 #(.TDATA_WIDTH(TDATA_WIDTH)) u_crc (
      .clk_i     (clk_i),
      .init_i    (crc_init),
      .en_i      (crc_en),
      .data_i    (video_i_tdata),
      .crc_o     (crc_q),
      .crc_upd_o (crc_upd)
   );

   // Publish the finished CRC together with the frame-done pulse
   always_ff @(posedge clk_i) begin
      if (rst_i)       frame_crc_o <= '0;
      else if (done_d) frame_crc_o <= (end_counted ? crc_upd : crc_q) ^ CRC_XOROUT;
   end
`else
   logic unused_crc;
   assign unused_crc  = &{1'b0, video_i_tdata, crc_init, crc_en, end_counted};
   assign frame_crc_o = '0;
`endif

endmodule

// File: tb/tb_axi4_video_frame_checker.sv
// Self-checking bench for axi4_video_frame_checker (X_ACTIVE=8, Y_ACTIVE=4).
// A line/pixel accounting model predicts every output each cycle; directed
// scenarios add literal expectations. Honors FRAME_CRC_EN like the design.
module tb_axi4_video_frame_checker;

   localparam int XA = 8;
   localparam int YA = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tdata;
   logic        tvalid, tlast, tuser, tready, err_clr;
   logic        done, ok;
   logic [3:0]  flags;
   logic [31:0] fcnt, crc;
   logic [15:0] ecnt;

   int checks = 0;
   int errors = 0;

   // model state
   bit          m_in, m_drain, m_ferr;
   int          m_pix, m_lines;
   logic [31:0] m_q[$];
   logic        exp_ready, exp_done, exp_ok;
   logic [3:0]  exp_flags;
   logic [31:0] exp_fcnt, exp_crc;
   logic [15:0] exp_ecnt;

   always #5 clk = ~clk;

   axi4_video_frame_checker #(.TDATA_WIDTH(32), .X_ACTIVE(XA), .Y_ACTIVE(YA)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .video_i_tdata   (tdata),
      .video_i_tvalid  (tvalid),
      .video_i_tlast   (tlast),
      .video_i_tuser   (tuser),
      .video_i_tready  (tready),
      .err_clr_i       (err_clr),
      .frame_done_o    (done),
      .frame_ok_o      (ok),
      .err_flags_o     (flags),
      .frame_cnt_o     (fcnt),
      .err_frame_cnt_o (ecnt),
      .frame_crc_o     (crc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] crc_of(input logic [31:0] q[$]);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      foreach (q[k]) begin
         for (int b = 31; b >= 0; b--) begin
            fb = c[31] ^ q[k][b];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
         end
      end
      return ~c;
   endfunction

   task automatic finish_frame(input bit good);
      exp_done = 1'b1;
      exp_ok   = good;
      if (good) exp_fcnt = exp_fcnt + 1;
      else if (exp_ecnt != 16'hFFFF) exp_ecnt = exp_ecnt + 1;
      exp_crc = crc_of(m_q);
   endtask

   // Predicts the outputs that follow the clock edge just taken.
   task automatic model_step();
      logic [3:0] set;
      bit         b;
      if (rst) begin
         exp_ready = 0; exp_done = 0; exp_ok = 0; exp_flags = 0;
         exp_fcnt = 0; exp_ecnt = 0; exp_crc = 0;
         m_in = 0; m_drain = 0; m_ferr = 0; m_pix = 0; m_lines = 0;
         m_q.delete();
         return;
      end
      set       = 4'b0000;
      exp_done  = 1'b0;
      b         = tvalid && exp_ready;
      exp_ready = 1'b1;
      if (b) begin
         if (tuser) begin
            if (m_in) begin
               set = set | 4'b1100;
               finish_frame(1'b0);
            end
            m_in = 1; m_drain = 0; m_pix = 0; m_lines = 0; m_ferr = 0;
            m_q.delete();
         end
         if (m_in) begin
            if (m_drain) begin
               if (tlast) begin
                  m_drain = 0;
                  m_lines++;
               end
            end else begin
               m_pix++;
               m_q.push_back(tdata);
               if (tlast) begin
                  if (m_pix != XA) begin
                     set[0] = 1'b1;
                     m_ferr = 1;
                  end
                  m_pix = 0;
                  m_lines++;
               end else if (m_pix == XA) begin
                  set[1]  = 1'b1;
                  m_ferr  = 1;
                  m_drain = 1;
                  m_pix   = 0;
               end
            end
            if (m_lines == YA) begin
               finish_frame(!m_ferr);
               m_in = 0;
            end
         end
      end
      exp_flags = (err_clr ? 4'b0000 : exp_flags) | set;
   endtask

   // Single compare process: model advances on each edge, outputs checked 1 time unit later
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         check("tready", {31'd0, tready}, {31'd0, exp_ready});
         check("frame_done", {31'd0, done}, {31'd0, exp_done});
         check("frame_ok", {31'd0, ok}, {31'd0, exp_ok});
         check("err_flags", {28'd0, flags}, {28'd0, exp_flags});
         check("frame_cnt", fcnt, exp_fcnt);
         check("err_frame_cnt", {16'd0, ecnt}, {16'd0, exp_ecnt});
`ifdef FRAME_CRC_EN
         check("frame_crc", crc, exp_crc);
`else
         check("frame_crc", crc, 32'd0);
`endif
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic send_beat(input logic [31:0] d, input bit u, input bit l, input bit clr);
      int k;
      while ($urandom_range(0, 1) == 1) begin
         tvalid = 0; tuser = 0; tlast = 0; err_clr = 0;
         @(negedge clk);
      end
      tvalid = 1; tdata = d; tuser = u; tlast = l; err_clr = clr;
      k = 0;
      while (!tready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!tready) check("tready_wait", {31'd0, tready}, 32'd1);
      @(negedge clk);
      tvalid = 0; tuser = 0; tlast = 0; err_clr = 0;
   endtask

   task automatic send_frame(input int l0, input int l1, input int l2, input int l3);
      int lens[4];
      int idx;
      lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
      idx = 0;
      for (int li = 0; li < 4; li++)
         for (int p = 0; p < lens[li]; p++) begin
            send_beat(idx, (li == 0) && (p == 0), p == lens[li] - 1, 1'b0);
            idx++;
         end
   endtask

   task automatic clear_flags();
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
   endtask

   logic [31:0] crc_a, crc_b;

   initial begin
      int len;
      bit u;
      rst = 1; tdata = 0; tvalid = 0; tlast = 0; tuser = 0; err_clr = 0;
      repeat (3) @(negedge clk);
      check("reset_tready", {31'd0, tready}, 32'd0);
      check("reset_flags", {28'd0, flags}, 32'd0);
      check("reset_fcnt", fcnt, 32'd0);
      rst = 0;

      // stray beats before any SOF are ignored
      repeat (3) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

      // three clean frames, identical pixel data
      for (int f = 0; f < 3; f++) begin
         send_frame(8, 8, 8, 8);
         check("clean_done", {31'd0, done}, 32'd1);
         check("clean_ok", {31'd0, ok}, 32'd1);
         if (f == 0) crc_a = crc;
         if (f == 1) crc_b = crc;
      end
      check("clean_fcnt", fcnt, 32'd3);
      check("clean_flags", {28'd0, flags}, 32'd0);
`ifdef FRAME_CRC_EN
      check("crc_repeat", crc_b, crc_a);
`endif

      // short line 1
      send_frame(8, 6, 8, 8);
      check("short_done", {31'd0, done}, 32'd1);
      check("short_ok", {31'd0, ok}, 32'd0);
      check("short_flags", {28'd0, flags}, 32'b0001);
      check("short_ecnt", {16'd0, ecnt}, 32'd1);
      clear_flags();
      check("clr_flags", {28'd0, flags}, 32'd0);

      // long line 2
      send_frame(8, 8, 10, 8);
      check("long_done", {31'd0, done}, 32'd1);
      check("long_ok", {31'd0, ok}, 32'd0);
      check("long_flags", {28'd0, flags}, 32'b0010);
      check("long_ecnt", {16'd0, ecnt}, 32'd2);
      clear_flags();

      // early SOF on pixel 3 of line 2, then a clean frame starting on that beat
      for (int i = 0; i < 19; i++) send_beat(i, i == 0, (i % 8) == 7, 1'b0);
      send_beat(0, 1'b1, 1'b0, 1'b0);
      check("sof_done", {31'd0, done}, 32'd1);
      check("sof_ok", {31'd0, ok}, 32'd0);
      check("sof_flags", {28'd0, flags}, 32'b1100);
      check("sof_ecnt", {16'd0, ecnt}, 32'd3);
      for (int i = 1; i < 32; i++) send_beat(i, 1'b0, (i % 8) == 7, 1'b0);
      check("after_sof_ok", {31'd0, ok}, 32'd1);
      check("after_sof_fcnt", fcnt, 32'd4);
      clear_flags();

      // clear coincides with a short line: set wins
      for (int i = 0; i < 5; i++) send_beat(i, i == 0, i == 4, i == 4);
      check("clr_set_flags", {28'd0, flags}, 32'b0001);
      for (int i = 0; i < 24; i++) send_beat(i, 1'b0, (i % 8) == 7, 1'b0);
      check("clr_set_ok", {31'd0, ok}, 32'd0);
      clear_flags();
      check("clr_only_flags", {28'd0, flags}, 32'd0);
      check("clr_only_fcnt", fcnt, 32'd4);
      check("clr_only_ecnt", {16'd0, ecnt}, 32'd4);

      // randomized frames with odd line lengths, stray SOFs and clears
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 3) == 0) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         for (int li = 0; li < YA; li++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 11)) : XA;
            for (int p = 0; p < len; p++) begin
               u = ((li == 0) && (p == 0)) || ($urandom_range(0, 59) == 0);
               send_beat($urandom, u, p == len - 1, $urandom_range(0, 9) == 0);
            end
         end
      end

      // reset in the middle of a frame
      for (int i = 0; i < 10; i++) send_beat(i, i == 0, (i % 8) == 7, 1'b0);
      rst = 1;
      repeat (2) @(negedge clk);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_fcnt", fcnt, 32'd0);
      check("midrst_ecnt", {16'd0, ecnt}, 32'd0);
      rst = 0;
      for (int i = 0; i < 6; i++) send_beat(i, 1'b0, (i % 3) == 2, 1'b0);
      send_frame(8, 8, 8, 8);
      check("midrst_after_ok", {31'd0, ok}, 32'd1);
      check("midrst_after_fcnt", fcnt, 32'd1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
